// File: rtl/i2c_slave_fsm.sv
// I2C target: 7-bit address, open-drain sda, NUM_BYTES
// write buffer and read server, oversampled on clk.
module i2c_slave_fsm #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_BYTES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data_1,
  input  logic [7:0] tx_data_2,
  output logic [7:0] rx_data_1,
  output logic [7:0] rx_data_2,
  output logic       rx_valid,
  output logic       busy,
  output logic [3:0] state_slave
);

  localparam int IW =
    (NUM_BYTES < 1) ? 1 : $clog2(NUM_BYTES + 1);
  localparam logic [IW-1:0] NB = IW'(NUM_BYTES);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    WR_DATA  = 4'd3,
    WR_ACK   = 4'd4,
    RD_DATA  = 4'd5,
    RD_ACK   = 4'd6,
    IGNORE   = 4'd7
  } state_t;

  state_t        state_q, state_n;
  logic          scl_m, scl_s, scl_d;
  logic          sda_m, sda_s, sda_d;
  logic [2:0]    bit_q, bit_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [7:0]    sh_q, sh_n;
  logic [7:0]    tx_q, tx_n;
  logic [7:0]    rx1_q, rx1_n;
  logic [7:0]    rx2_q, rx2_n;
  logic          oe_q, oe_n;
  logic          rw_q, rw_n;
  logic          full_q, full_n;
  logic          load_q, load_n;
  logic          ack_q, ack_n;
  logic          vld_q, vld_n;
  logic          rise, fall, start, stop;
  logic [7:0]    tx_byte;
  logic [7:0]    sh_in;

  assign rise  = scl_s & ~scl_d;
  assign fall  = ~scl_s & scl_d;
  assign start = scl_s & sda_d & ~sda_s;
  assign stop  = scl_s & ~sda_d & sda_s;
  assign sh_in = {sh_q[6:0], sda_s};

  always_comb begin
    if (idx_q >= NB)          tx_byte = 8'hFF;
    else if (idx_q == '0)     tx_byte = tx_data_1;
    else                      tx_byte = tx_data_2;
  end

  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    idx_n   = idx_q;
    sh_n    = sh_q;
    tx_n    = tx_q;
    rx1_n   = rx1_q;
    rx2_n   = rx2_q;
    oe_n    = oe_q;
    rw_n    = rw_q;
    full_n  = full_q;
    load_n  = load_q;
    ack_n   = ack_q;
    vld_n   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      bit_n   = 3'd0;
      idx_n   = '0;
      oe_n    = 1'b0;
      full_n  = 1'b0;
      load_n  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (rise) begin
            sh_n   = sh_in;
            bit_n  = bit_q + 3'd1;
            full_n = (bit_q == 3'd7);
          end else if (fall && full_q) begin
            full_n = 1'b0;
            rw_n   = sh_q[0];
            if (sh_q[7:1] == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              oe_n    = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            if (rw_q) begin
              state_n = RD_DATA;
              tx_n    = tx_byte;
              oe_n    = ~tx_byte[7];
              bit_n   = 3'd1;
            end else begin
              state_n = WR_DATA;
              oe_n    = 1'b0;
              bit_n   = 3'd0;
            end
          end
        end
        WR_DATA: begin
          if (rise) begin
            sh_n  = sh_in;
            bit_n = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              full_n = 1'b1;
              ack_n  = (idx_q < NB);
              if (idx_q < NB) begin
                vld_n = 1'b1;
                idx_n = idx_q + IW'(1);
                if (idx_q == '0) rx1_n = sh_in;
                else if (idx_q == IW'(1)) rx2_n = sh_in;
              end
            end
          end else if (fall && full_q) begin
            full_n  = 1'b0;
            state_n = WR_ACK;
            oe_n    = ack_q;
          end
        end
        WR_ACK: begin
          if (fall) begin
            state_n = WR_DATA;
            oe_n    = 1'b0;
            bit_n   = 3'd0;
          end
        end
        RD_DATA: begin
          // bit_q counts bits already presented; 0 = byte done
          if (fall) begin
            if (load_q) begin
              load_n = 1'b0;
              tx_n   = tx_byte;
              oe_n   = ~tx_byte[7];
              bit_n  = 3'd1;
            end else if (bit_q == 3'd0) begin
              state_n = RD_ACK;
              oe_n    = 1'b0;
            end else begin
              oe_n  = ~tx_q[6];
              tx_n  = {tx_q[6:0], 1'b0};
              bit_n = bit_q + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (rise) begin
            if (!sda_s) begin
              state_n = RD_DATA;
              load_n  = 1'b1;
              if (idx_q < NB) idx_n = idx_q + IW'(1);
            end else begin
              state_n = IGNORE;
            end
          end
        end
        IGNORE: state_n = IGNORE;
        IDLE:   state_n = IDLE;
        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scl_m   <= 1'b1;
      scl_s   <= 1'b1;
      scl_d   <= 1'b1;
      sda_m   <= 1'b1;
      sda_s   <= 1'b1;
      sda_d   <= 1'b1;
      bit_q   <= 3'd0;
      idx_q   <= '0;
      sh_q    <= 8'h00;
      tx_q    <= 8'h00;
      rx1_q   <= 8'h00;
      rx2_q   <= 8'h00;
      oe_q    <= 1'b0;
      rw_q    <= 1'b0;
      full_q  <= 1'b0;
      load_q  <= 1'b0;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      scl_m   <= scl;
      scl_s   <= scl_m;
      scl_d   <= scl_s;
      sda_m   <= sda;
      sda_s   <= sda_m;
      sda_d   <= sda_s;
      bit_q   <= bit_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
      tx_q    <= tx_n;
      rx1_q   <= rx1_n;
      rx2_q   <= rx2_n;
      oe_q    <= oe_n;
      rw_q    <= rw_n;
      full_q  <= full_n;
      load_q  <= load_n;
      ack_q   <= ack_n;
      vld_q   <= vld_n;
    end
  end

  assign sda         = oe_q ? 1'b0 : 1'bz;
  assign rx_data_1   = rx1_q;
  assign rx_data_2   = rx2_q;
  assign rx_valid    = vld_q;
  assign busy        = (state_q != IDLE);
  assign state_slave = state_q;

endmodule

// File: doc/i2c_slave_fsm.md
I2C_SLAVE_FSM -- requirements
Module: i2c_slave_fsm

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit address this target answers to.
REQ-002 SHALL have parameter NUM_BYTES, default 2: bytes accepted per write and served per read.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port scl, input, 1 bit: bus clock from the master.
REQ-006 SHALL have port sda, inout, 1 bit: bus data, open-drain (block drives only 1'b0 or 1'bz).
REQ-007 SHALL have ports tx_data_1 and tx_data_2, input, 8 bits each: read bytes 0 and 1.
REQ-008 SHALL have ports rx_data_1 and rx_data_2, output, 8 bits each: last written bytes 0 and 1.
REQ-009 SHALL have port rx_valid, output, 1 bit: one-clk pulse per stored write byte.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port state_slave, output, 4 bits: current FSM state encoding.

Function
REQ-012 SHALL pass scl and sda through 2-flop synchronizers (scl_s, sda_s), and SHALL detect the following events from scl_s/sda_s and their delayed copies:
- rise/fall = scl_s edge.
- START = sda_s 1->0 while scl_s=1.
- STOP = sda_s 0->1 while scl_s=1.
REQ-013 SHALL use these states: IDLE=0, ADDR=1, ADDR_ACK=2, WR_DATA=3, WR_ACK=4, RD_DATA=5, RD_ACK=6, IGNORE=7.
REQ-014 SHALL handle START in any state as follows:
- Go to ADDR.
- Clear bit counter and byte index.
- Release sda.
- This covers repeated START.
REQ-015 SHALL, on STOP in any state, go to IDLE and release sda; STOP has priority over all other events in the same clk.
REQ-016 SHALL, in ADDR, shift sda_s MSB-first into an 8-bit register on each rise; after the 8th rise, bits[7:1] are the address and bit[0] is R/W.
REQ-017 SHALL, on the fall after the 8th address bit:
- If address == SLAVE_ADDR, drive sda=0 and go to ADDR_ACK.
- Otherwise go to IGNORE with sda released.
REQ-018 SHALL, on the next fall in ADDR_ACK:
- If R/W=0, release sda and go to WR_DATA.
- If R/W=1, go to RD_DATA and drive bit 7 of the current tx byte.
REQ-019 SHALL, in WR_DATA:
- Shift 8 bits on rise.
- After the 8th, if byte index < NUM_BYTES, write rx_data_{index+1}, pulse rx_valid for 1 clk, and increment the index.
- On the following fall, go to WR_ACK, driving sda=0 if the byte was stored, else releasing sda (NACK).
REQ-020 SHALL, on the next fall in WR_ACK, release sda, clear the bit counter and return to WR_DATA.
REQ-021 SHALL, in RD_DATA, on each fall present the next bit MSB-first: bit=0 drives sda=0, bit=1 releases sda.
REQ-022 SHALL, after 8 bits in RD_DATA:
- Release sda at the next fall and go to RD_ACK.
- Sample sda_s on the following rise: 0 (ACK) means increment the byte index and return to RD_DATA, driving bit 7 at the next fall; 1 (NACK) means go to IGNORE.
REQ-023 SHALL read tx_data_1 for index 0 and tx_data_2 for index 1; index >= NUM_BYTES SHALL supply 8'hFF.
REQ-024 SHALL capture each tx byte into a shift register at the fall that drives its bit 7; later tx_data changes SHALL NOT affect that byte.
REQ-025 SHALL, in IGNORE, keep sda released and leave only on START or STOP.
REQ-026 SHALL update the sda drive within 4 clk of a pin-level scl fall. The environment SHALL guarantee scl high and low phases of >= 6 clk each.
REQ-027 SHALL use a 3-bit bit counter that wraps 7->0 at each byte boundary, and a byte index that saturates at NUM_BYTES.

Reset
REQ-028 SHALL, while rst_n=0 at posedge clk, set all outputs and state as follows:
- State IDLE, sda released.
- rx_data_1 = rx_data_2 = 8'h00.
- rx_valid = 0, busy = 0, state_slave = 0.
- Counters = 0, synchronizer flops = 1.
REQ-029 SHALL, on reset asserted mid-transfer, release sda in the same clk edge; after release the block SHALL ignore the bus until the next START.

Verification
REQ-030 SHALL cover write: START, 0xA0, 0x3C, 0x81, STOP -> ACK on all 3 bytes; rx_data_1=8'h3C; rx_data_2=8'h81; exactly 2 rx_valid pulses; busy=0 after STOP.
REQ-031 SHALL cover read: tx_data_1=8'h5A, tx_data_2=8'hC3; START, 0xA1, master ACK then NACK -> address ACKed; sda bits 01011010 then 11000011; state IGNORE then IDLE on STOP.
REQ-032 SHALL cover wrong address: START, 0xA2 -> sda never driven; state IGNORE until STOP; rx_data unchanged.
REQ-033 SHALL cover overflow: write of 3 data bytes 0x11, 0x22, 0x33 -> 3rd byte NACKed; rx_data_2=8'h22; 2 rx_valid pulses; 3rd read byte (if read) = 8'hFF.
REQ-034 SHALL cover repeated START: write 0xA0, 0x07, then START, 0xA1 -> state returns to ADDR; read byte index restarts at 0 (returns tx_data_1).
REQ-035 SHALL cover reset: rst_n=0 during RD_DATA while sda driven low -> sda=z at that edge; all outputs at reset values; next valid transaction completes normally.
